// File: rtl/smartcargo_pkg.sv
// smartcargo_pkg
// Shared definitions for the SmartCargo elevator movement control unit:
//   - estado_t : 4-bit state codes of the movement FSM (also exported on db_estado)
//   - SOBE/DESCE : encoding of the travel direction register
package smartcargo_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    INICIALIZA  = 4'd1,
    PROX_PEDIDO = 4'd2,
    AVALIA      = 4'd3,
    SUBINDO     = 4'd4,
    DESCENDO    = 4'd5,
    REGISTRA_S  = 4'd6,
    REGISTRA_D  = 4'd7,
    CHECA       = 4'd8,
    ENTRA       = 4'd9,
    SAI         = 4'd10,
    RECUSA      = 4'd11,
    SHIFT       = 4'd12,
    AGUARDA     = 4'd13,
    ERRO        = 4'd14
  } estado_t;

  localparam logic SOBE  = 1'b1;
  localparam logic DESCE = 1'b0;

endpackage

// File: rtl/contador_m.sv
// contador_m
// Generic terminal-count timer. Counts up while 'conta' is high and wraps to
// zero after reaching 'limite'; 'zera' clears it and has priority over 'conta'.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   zera         : synchronous clear
//   conta        : count enable
//   limite       : terminal value (W bits), may change cycle by cycle
//   fim          : high while the current count equals 'limite'
module contador_m #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  input  logic [W-1:0] limite,
  output logic         fim
);

  logic [W-1:0] valor_q;
  logic [W-1:0] valor_d;

  // fim is decoded from the stored count so the owner can react in the same
  // cycle the terminal value is reached.
  assign fim = (valor_q == limite);

  always_comb begin
    valor_d = valor_q;
    if (zera) begin
      valor_d = '0;
    end else if (conta) begin
      valor_d = fim ? '0 : valor_q + W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

endmodule

// File: rtl/uc_movimento_param.sv
// uc_movimento_param
// Movement control unit for the SmartCargo elevator. Serves the request at the
// head of the queue: travels up/down counting floors from the sensor edge
// pulse, loads/unloads (or refuses when full) at the destination, pops the
// queue and keeps the door open for T_PORTA cycles. A travel watchdog and
// floor-range checks drop the unit into a latched fault state.
// Ports:
//   clock, reset        : clock, asynchronous active-high reset
//   iniciar             : start pulse
//   temDestino, destino : queue head valid / floor of the queue head
//   eh_origem           : 1 = pickup at head floor, 0 = dropoff
//   bordaSensorAtivo    : one pulse per floor passed
//   shift               : one-cycle queue pop
//   coloca_objetos      : one-cycle load pulse
//   tira_objetos        : one-cycle unload pulse
//   recusado            : one-cycle pulse when a pickup is refused (car full)
//   motorSubindo/Descendo : motor commands, mutually exclusive
//   andar_atual, ocupacao : current floor, objects on board
//   erro                : latched fault, cleared only by reset
//   db_estado           : current state code
module uc_movimento_param
  import smartcargo_pkg::*;
#(
  parameter int N_ANDARES  = 8,
  parameter int W_ANDAR    = $clog2(N_ANDARES),
  parameter int T_PORTA    = 50,
  parameter int T_VIAGEM   = 1000,
  parameter int CAPACIDADE = 4,
  parameter int W_OCUP     = $clog2(CAPACIDADE + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               temDestino,
  input  logic [W_ANDAR-1:0] destino,
  input  logic               eh_origem,
  input  logic               bordaSensorAtivo,
  output logic               shift,
  output logic               coloca_objetos,
  output logic               tira_objetos,
  output logic               recusado,
  output logic               motorSubindo,
  output logic               motorDescendo,
  output logic [W_ANDAR-1:0] andar_atual,
  output logic [W_OCUP-1:0]  ocupacao,
  output logic               erro,
  output logic [3:0]         db_estado
);

  // One timer serves both the travel watchdog and the door dwell, so it must
  // be wide enough for the larger of the two limits.
  localparam int T_MAX = (T_VIAGEM > T_PORTA) ? T_VIAGEM : T_PORTA;
  localparam int W_TMR = $clog2(T_MAX + 1);

  localparam logic [W_TMR-1:0]   LIM_VIAGEM = W_TMR'(T_VIAGEM - 1);
  localparam logic [W_TMR-1:0]   LIM_PORTA  = W_TMR'(T_PORTA - 1);
  localparam logic [W_ANDAR-1:0] ANDAR_TOPO = W_ANDAR'(N_ANDARES - 1);
  localparam logic [W_OCUP-1:0]  OCUP_MAX   = W_OCUP'(CAPACIDADE);

  estado_t            estado_q, estado_d;
  logic               dir_q, dir_d;
  logic [W_ANDAR-1:0] andar_q, andar_d;
  logic [W_OCUP-1:0]  ocup_q, ocup_d;

  logic shift_q, shift_d;
  logic coloca_q, coloca_d;
  logic tira_q, tira_d;
  logic recusado_q, recusado_d;
  logic sobe_q, sobe_d;
  logic desce_q, desce_d;
  logic erro_q, erro_d;

  logic             zera_tmr;
  logic             conta_tmr;
  logic             fim_tmr;
  logic [W_TMR-1:0] limite_tmr;
  logic             fora_destino_d;

  // Only the dwell state uses the door limit; every other counting state is
  // travelling and therefore uses the watchdog limit.
  assign limite_tmr = (estado_q == AGUARDA) ? LIM_PORTA : LIM_VIAGEM;

  contador_m #(
    .W(W_TMR)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .zera  (zera_tmr),
    .conta (conta_tmr),
    .limite(limite_tmr),
    .fim   (fim_tmr)
  );

  // Next-state and datapath logic. The sensor edge is checked before the
  // watchdog so a pulse arriving on the expiry cycle still counts as a floor.
  // Reaching the top/bottom floor and still seeing an edge in that direction
  // means the sensor disagrees with the floor count, so the unit faults
  // instead of wrapping the counter.
  always_comb begin
    estado_d  = estado_q;
    dir_d     = dir_q;
    andar_d   = andar_q;
    ocup_d    = ocup_q;
    zera_tmr  = 1'b0;
    conta_tmr = 1'b0;

    case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = INICIALIZA;
      end
      INICIALIZA: begin
        andar_d  = '0;
        ocup_d   = '0;
        zera_tmr = 1'b1;
        estado_d = PROX_PEDIDO;
      end
      PROX_PEDIDO: begin
        zera_tmr = 1'b1;
        if (temDestino) estado_d = AVALIA;
      end
      AVALIA: begin
        if (destino > andar_q) begin
          dir_d    = SOBE;
          estado_d = SUBINDO;
        end else if (destino < andar_q) begin
          dir_d    = DESCE;
          estado_d = DESCENDO;
        end else begin
          estado_d = CHECA;
        end
      end
      SUBINDO: begin
        conta_tmr = 1'b1;
        if (bordaSensorAtivo) begin
          estado_d = (andar_q == ANDAR_TOPO) ? ERRO : REGISTRA_S;
        end else if (fim_tmr) begin
          estado_d = ERRO;
        end
      end
      DESCENDO: begin
        conta_tmr = 1'b1;
        if (bordaSensorAtivo) begin
          estado_d = (andar_q == '0) ? ERRO : REGISTRA_D;
        end else if (fim_tmr) begin
          estado_d = ERRO;
        end
      end
      REGISTRA_S: begin
        andar_d  = andar_q + W_ANDAR'(1);
        zera_tmr = 1'b1;
        estado_d = CHECA;
      end
      REGISTRA_D: begin
        andar_d  = andar_q - W_ANDAR'(1);
        zera_tmr = 1'b1;
        estado_d = CHECA;
      end
      CHECA: begin
        if (andar_q == destino) begin
          if (!eh_origem)             estado_d = SAI;
          else if (ocup_q < OCUP_MAX) estado_d = ENTRA;
          else                        estado_d = RECUSA;
        end else begin
          estado_d = (dir_q == SOBE) ? SUBINDO : DESCENDO;
        end
      end
      ENTRA: begin
        ocup_d   = ocup_q + W_OCUP'(1);
        estado_d = SHIFT;
      end
      SAI: begin
        // Dropping off with an empty car keeps occupancy at zero.
        ocup_d   = (ocup_q == '0) ? '0 : ocup_q - W_OCUP'(1);
        estado_d = SHIFT;
      end
      RECUSA: begin
        estado_d = SHIFT;
      end
      SHIFT: begin
        zera_tmr = 1'b1;
        estado_d = AGUARDA;
      end
      AGUARDA: begin
        conta_tmr = 1'b1;
        if (fim_tmr) estado_d = PROX_PEDIDO;
      end
      ERRO: begin
        estado_d = ERRO;
      end
      default: begin
        estado_d = INICIAL;
      end
    endcase

    // Outputs are decoded from the next state and next datapath values and
    // then registered, so each output flop holds exactly the Moore function
    // of the state it is presented alongside. The motor stays on through
    // REGISTRA and CHECA while the destination has not been reached, which
    // keeps the command continuous across floor boundaries.
    fora_destino_d = (andar_d != destino);
    sobe_d     = (estado_d == SUBINDO) || (estado_d == REGISTRA_S) ||
                 ((estado_d == CHECA) && (dir_d == SOBE) && fora_destino_d);
    desce_d    = (estado_d == DESCENDO) || (estado_d == REGISTRA_D) ||
                 ((estado_d == CHECA) && (dir_d == DESCE) && fora_destino_d);
    shift_d    = (estado_d == SHIFT);
    coloca_d   = (estado_d == ENTRA);
    tira_d     = (estado_d == SAI);
    recusado_d = (estado_d == RECUSA);
    erro_d     = (estado_d == ERRO);
  end

  // State, datapath and registered outputs; reset clears the motor commands
  // immediately without waiting for a clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= INICIAL;
      dir_q      <= DESCE;
      andar_q    <= '0;
      ocup_q     <= '0;
      shift_q    <= 1'b0;
      coloca_q   <= 1'b0;
      tira_q     <= 1'b0;
      recusado_q <= 1'b0;
      sobe_q     <= 1'b0;
      desce_q    <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      dir_q      <= dir_d;
      andar_q    <= andar_d;
      ocup_q     <= ocup_d;
      shift_q    <= shift_d;
      coloca_q   <= coloca_d;
      tira_q     <= tira_d;
      recusado_q <= recusado_d;
      sobe_q     <= sobe_d;
      desce_q    <= desce_d;
      erro_q     <= erro_d;
    end
  end

  assign shift          = shift_q;
  assign coloca_objetos = coloca_q;
  assign tira_objetos   = tira_q;
  assign recusado       = recusado_q;
  assign motorSubindo   = sobe_q;
  assign motorDescendo  = desce_q;
  assign andar_atual    = andar_q;
  assign ocupacao       = ocup_q;
  assign erro           = erro_q;
  assign db_estado      = estado_q;

endmodule

// File: tb/tb_uc_movimento_param.sv
// tb_uc_movimento_param
// Self-checking bench for uc_movimento_param. A reference model pushes the
// expected outcome of each request (action, floor, occupancy) into a queue;
// a monitor records what the DUT does at every shift pulse and the scenario
// tasks pop and compare both. A second instance with 6 floors exercises the
// floor-range fault, which needs an out-of-range destination.
module tb_uc_movimento_param;

  localparam int N   = 8;
  localparam int TP  = 50;
  localparam int TV  = 20;
  localparam int CAP = 2;

  localparam logic [1:0] ACT_NONE   = 2'd0;
  localparam logic [1:0] ACT_LOAD   = 2'd1;
  localparam logic [1:0] ACT_UNLOAD = 2'd2;
  localparam logic [1:0] ACT_REFUSE = 2'd3;

  typedef struct packed {
    logic [1:0] act;
    logic [2:0] andar;
    logic [1:0] occ;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar, temDestino, eh_origem, bordaSensorAtivo;
  logic [2:0] destino;
  logic       shift, coloca_objetos, tira_objetos, recusado;
  logic       motorSubindo, motorDescendo, erro;
  logic [2:0] andar_atual;
  logic [1:0] ocupacao;
  logic [3:0] db_estado;

  logic       b_reset, b_iniciar, b_temDestino, b_eh_origem, b_borda;
  logic [2:0] b_destino;
  logic       b_shift, b_coloca, b_tira, b_recusado, b_sobe, b_desce, b_erro;
  logic [2:0] b_andar;
  logic [2:0] b_ocup;
  logic [3:0] b_db;

  int checks   = 0;
  int failures = 0;

  ev_t  exp_q[$];
  ev_t  obs_q[$];
  logic [1:0] last_act = ACT_NONE;
  int shift_cnt  = 0;
  int coloca_cnt = 0;
  int tira_cnt   = 0;
  int recusa_cnt = 0;
  int both_cnt   = 0;
  int model_floor = 0;
  int model_occ   = 0;

  uc_movimento_param #(
    .N_ANDARES (N),
    .T_PORTA   (TP),
    .T_VIAGEM  (TV),
    .CAPACIDADE(CAP)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .iniciar         (iniciar),
    .temDestino      (temDestino),
    .destino         (destino),
    .eh_origem       (eh_origem),
    .bordaSensorAtivo(bordaSensorAtivo),
    .shift           (shift),
    .coloca_objetos  (coloca_objetos),
    .tira_objetos    (tira_objetos),
    .recusado        (recusado),
    .motorSubindo    (motorSubindo),
    .motorDescendo   (motorDescendo),
    .andar_atual     (andar_atual),
    .ocupacao        (ocupacao),
    .erro            (erro),
    .db_estado       (db_estado)
  );

  uc_movimento_param #(
    .N_ANDARES(6),
    .T_VIAGEM (TV)
  ) dut_b (
    .clock           (clock),
    .reset           (b_reset),
    .iniciar         (b_iniciar),
    .temDestino      (b_temDestino),
    .destino         (b_destino),
    .eh_origem       (b_eh_origem),
    .bordaSensorAtivo(b_borda),
    .shift           (b_shift),
    .coloca_objetos  (b_coloca),
    .tira_objetos    (b_tira),
    .recusado        (b_recusado),
    .motorSubindo    (b_sobe),
    .motorDescendo   (b_desce),
    .andar_atual     (b_andar),
    .ocupacao        (b_ocup),
    .erro            (b_erro),
    .db_estado       (b_db)
  );

  always #5 clock = ~clock;

  // Monitor on the falling edge: remembers which action pulse preceded each
  // shift and records the resulting floor/occupancy as one observed event.
  always @(negedge clock) begin
    if (reset) begin
      last_act = ACT_NONE;
    end else begin
      if (motorSubindo && motorDescendo) both_cnt++;
      if (coloca_objetos) begin last_act = ACT_LOAD;   coloca_cnt++; end
      if (tira_objetos)   begin last_act = ACT_UNLOAD; tira_cnt++;   end
      if (recusado)       begin last_act = ACT_REFUSE; recusa_cnt++; end
      if (shift) begin
        obs_q.push_back('{act: last_act, andar: andar_atual, occ: ocupacao});
        shift_cnt++;
        last_act = ACT_NONE;
      end
    end
  end

  // Reference model: outcome of one request given the model's occupancy.
  task automatic model_push(input int dest, input bit orig);
    ev_t e;
    if (orig) begin
      if (model_occ < CAP) begin e.act = ACT_LOAD; model_occ++; end
      else                 e.act = ACT_REFUSE;
    end else begin
      e.act = ACT_UNLOAD;
      if (model_occ > 0) model_occ--;
    end
    e.andar = 3'(dest);
    e.occ   = 2'(model_occ);
    model_floor = dest;
    exp_q.push_back(e);
  endtask

  // Reset and start the main DUT; returns one cycle into PROX_PEDIDO.
  task automatic init_dut();
    reset = 1'b1; iniciar = 1'b0; temDestino = 1'b0; eh_origem = 1'b0;
    bordaSensorAtivo = 1'b0; destino = '0;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(negedge clock); iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    @(posedge clock); #1;
    exp_q.delete(); obs_q.delete();
    model_floor = 0; model_occ = 0;
  endtask

  // Presents one request and feeds sensor pulses every 'gap' moving cycles
  // until the DUT pops the queue, then measures the door dwell.
  task automatic applyStimulus(input logic [2:0] dest, input logic orig, input int gap,
                               output bit done, output int dwell, output int first_motor,
                               output int motor_cycles, output bit motor_gap);
    int cnt = 0;
    done = 0; dwell = 0; first_motor = -1; motor_cycles = 0; motor_gap = 0;
    temDestino = 1'b1; destino = dest; eh_origem = orig; bordaSensorAtivo = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clock); #1;
      bordaSensorAtivo = 1'b0;
      if (shift) begin done = 1; break; end
      if (motorSubindo || motorDescendo) begin
        motor_cycles++;
        if (first_motor < 0) first_motor = c;
      end else if (first_motor >= 0 && andar_atual != dest) begin
        motor_gap = 1;
      end
      if (db_estado == 4'd4 || db_estado == 4'd5) begin
        cnt++;
        if (cnt >= gap) begin bordaSensorAtivo = 1'b1; cnt = 0; end
      end
    end
    temDestino = 1'b0;
    if (done) begin
      for (int c = 0; c < 200; c++) begin
        @(posedge clock); #1;
        if (db_estado == 4'd2) break;
        dwell++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; iniciar = 1'b0; temDestino = 1'b0; eh_origem = 1'b0;
    bordaSensorAtivo = 1'b0; destino = '0;
    b_reset = 1'b1; b_iniciar = 1'b0; b_temDestino = 1'b0; b_eh_origem = 1'b0;
    b_borda = 1'b0; b_destino = '0;
    #12;
    checks++; if (db_estado !== 4'd0) begin failures++; $display("[TB] FAIL reset_state got=%0d want=0", db_estado); end
    checks++; if (andar_atual !== 3'd0) begin failures++; $display("[TB] FAIL reset_floor got=%0d want=0", andar_atual); end
    checks++; if (ocupacao !== 2'd0) begin failures++; $display("[TB] FAIL reset_occ got=%0d want=0", ocupacao); end
    checks++; if (erro !== 1'b0) begin failures++; $display("[TB] FAIL reset_erro got=%0b want=0", erro); end
    checks++; if ({motorSubindo, motorDescendo} !== 2'b00) begin failures++; $display("[TB] FAIL reset_motor got=%b want=00", {motorSubindo, motorDescendo}); end
    checks++; if ({shift, coloca_objetos, tira_objetos, recusado} !== 4'b0) begin failures++; $display("[TB] FAIL reset_pulses got=%b want=0000", {shift, coloca_objetos, tira_objetos, recusado}); end
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (db_estado !== 4'd0) begin failures++; $display("[TB] FAIL idle_without_iniciar got=%0d want=0", db_estado); end
    @(negedge clock); iniciar = 1'b1;
    @(posedge clock); #1; iniciar = 1'b0;
    checks++; if (db_estado !== 4'd1) begin failures++; $display("[TB] FAIL start_inicializa got=%0d want=1", db_estado); end
    @(posedge clock); #1;
    checks++; if (db_estado !== 4'd2) begin failures++; $display("[TB] FAIL start_prox_pedido got=%0d want=2", db_estado); end
    exp_q.delete(); obs_q.delete(); model_floor = 0; model_occ = 0;
  endtask

  task automatic test_pickup();
    bit done, gapm; int dwell, fm, mc; int c0, s0; ev_t e, o;
    c0 = coloca_cnt; s0 = shift_cnt;
    model_push(3, 1'b1);
    applyStimulus(3'd3, 1'b1, 10, done, dwell, fm, mc, gapm);
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL pickup_done got=%0b want=1", done); end
    checks++; if (fm != 1) begin failures++; $display("[TB] FAIL pickup_motor_latency got=%0d want=1", fm); end
    checks++; if (gapm !== 1'b0) begin failures++; $display("[TB] FAIL pickup_motor_continuous got=%0b want=0", gapm); end
    checks++; if (dwell != TP) begin failures++; $display("[TB] FAIL pickup_dwell got=%0d want=%0d", dwell, TP); end
    checks++; if (andar_atual !== 3'd3) begin failures++; $display("[TB] FAIL pickup_floor got=%0d want=3", andar_atual); end
    checks++; if (ocupacao !== 2'd1) begin failures++; $display("[TB] FAIL pickup_occ got=%0d want=1", ocupacao); end
    checks++; if (coloca_cnt - c0 != 1) begin failures++; $display("[TB] FAIL pickup_load_pulses got=%0d want=1", coloca_cnt - c0); end
    checks++; if (shift_cnt - s0 != 1) begin failures++; $display("[TB] FAIL pickup_shift_pulses got=%0d want=1", shift_cnt - s0); end
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin failures++; $display("[TB] FAIL pickup_scoreboard got=none want=act%0d/floor%0d/occ%0d", e.act, e.andar, e.occ); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin failures++; $display("[TB] FAIL pickup_scoreboard got=act%0d/floor%0d/occ%0d want=act%0d/floor%0d/occ%0d", o.act, o.andar, o.occ, e.act, e.andar, e.occ); end
    end
  endtask

  task automatic test_dropoff();
    bit done, gapm; int dwell, fm, mc; int t0; ev_t e, o;
    t0 = tira_cnt;
    model_push(3, 1'b0);
    applyStimulus(3'd3, 1'b0, 5, done, dwell, fm, mc, gapm);
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL dropoff_done got=%0b want=1", done); end
    checks++; if (mc != 0) begin failures++; $display("[TB] FAIL dropoff_no_motor got=%0d want=0", mc); end
    checks++; if (ocupacao !== 2'd0) begin failures++; $display("[TB] FAIL dropoff_occ got=%0d want=0", ocupacao); end
    checks++; if (tira_cnt - t0 != 1) begin failures++; $display("[TB] FAIL dropoff_unload_pulses got=%0d want=1", tira_cnt - t0); end
    checks++; if (dwell != TP) begin failures++; $display("[TB] FAIL dropoff_dwell got=%0d want=%0d", dwell, TP); end
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin failures++; $display("[TB] FAIL dropoff_scoreboard got=none want=act%0d", e.act); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin failures++; $display("[TB] FAIL dropoff_scoreboard got=act%0d/floor%0d/occ%0d want=act%0d/floor%0d/occ%0d", o.act, o.andar, o.occ, e.act, e.andar, e.occ); end
    end
  endtask

  task automatic test_capacity();
    bit done, gapm; int dwell, fm, mc; int c0, r0, s0; ev_t e, o;
    c0 = coloca_cnt; r0 = recusa_cnt; s0 = shift_cnt;
    for (int i = 0; i < 3; i++) begin
      model_push(3, 1'b1);
      applyStimulus(3'd3, 1'b1, 5, done, dwell, fm, mc, gapm);
      checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL capacity_done[%0d] got=%0b want=1", i, done); end
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("[TB] FAIL capacity_scoreboard[%0d] got=none want=act%0d", i, e.act); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("[TB] FAIL capacity_scoreboard[%0d] got=act%0d/occ%0d want=act%0d/occ%0d", i, o.act, o.occ, e.act, e.occ); end
      end
    end
    checks++; if (coloca_cnt - c0 != 2) begin failures++; $display("[TB] FAIL capacity_loads got=%0d want=2", coloca_cnt - c0); end
    checks++; if (recusa_cnt - r0 != 1) begin failures++; $display("[TB] FAIL capacity_refusals got=%0d want=1", recusa_cnt - r0); end
    checks++; if (shift_cnt - s0 != 3) begin failures++; $display("[TB] FAIL capacity_shifts got=%0d want=3", shift_cnt - s0); end
    checks++; if (ocupacao !== 2'd2) begin failures++; $display("[TB] FAIL capacity_occ got=%0d want=2", ocupacao); end
  endtask

  task automatic test_watchdog();
    int n; bit left_early; bit done, gapm; int dwell, fm, mc; ev_t e, o;
    // Floor 3, request floor 0, no sensor pulses at all.
    temDestino = 1'b1; destino = 3'd0; eh_origem = 1'b0;
    for (int c = 0; c < 10; c++) begin @(posedge clock); #1; if (db_estado == 4'd5) break; end
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (db_estado != 4'd5) break;
      n++;
      @(posedge clock); #1;
    end
    checks++; if (n != TV) begin failures++; $display("[TB] FAIL watchdog_cycles got=%0d want=%0d", n, TV); end
    checks++; if (db_estado !== 4'd14) begin failures++; $display("[TB] FAIL watchdog_state got=%0d want=14", db_estado); end
    checks++; if ({motorSubindo, motorDescendo} !== 2'b00) begin failures++; $display("[TB] FAIL watchdog_motor got=%b want=00", {motorSubindo, motorDescendo}); end
    bordaSensorAtivo = 1'b1;
    repeat (30) @(posedge clock);
    #1; bordaSensorAtivo = 1'b0;
    checks++; if (erro !== 1'b1) begin failures++; $display("[TB] FAIL watchdog_erro_latched got=%0b want=1", erro); end
    checks++; if (db_estado !== 4'd14) begin failures++; $display("[TB] FAIL watchdog_absorbing got=%0d want=14", db_estado); end
    init_dut();
    checks++; if (erro !== 1'b0) begin failures++; $display("[TB] FAIL watchdog_erro_cleared got=%0b want=0", erro); end

    // Edge arriving in the very cycle the watchdog expires keeps the car moving.
    temDestino = 1'b1; destino = 3'd2; eh_origem = 1'b0;
    for (int c = 0; c < 10; c++) begin @(posedge clock); #1; if (db_estado == 4'd4) break; end
    left_early = (db_estado != 4'd4);
    for (int k = 1; k < TV; k++) begin
      @(posedge clock); #1;
      if (db_estado != 4'd4) left_early = 1;
    end
    bordaSensorAtivo = 1'b1;
    @(posedge clock); #1; bordaSensorAtivo = 1'b0;
    checks++; if (left_early !== 1'b0) begin failures++; $display("[TB] FAIL expiry_stayed_moving got=%0b want=0", left_early); end
    checks++; if (db_estado !== 4'd6) begin failures++; $display("[TB] FAIL expiry_edge_wins got=%0d want=6", db_estado); end
    checks++; if (motorSubindo !== 1'b1) begin failures++; $display("[TB] FAIL expiry_motor got=%0b want=1", motorSubindo); end
    model_push(2, 1'b0);
    applyStimulus(3'd2, 1'b0, 5, done, dwell, fm, mc, gapm);
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL expiry_done got=%0b want=1", done); end
    checks++; if (ocupacao !== 2'd0) begin failures++; $display("[TB] FAIL empty_dropoff_occ got=%0d want=0", ocupacao); end
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin failures++; $display("[TB] FAIL expiry_scoreboard got=none want=act%0d", e.act); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin failures++; $display("[TB] FAIL expiry_scoreboard got=act%0d/floor%0d/occ%0d want=act%0d/floor%0d/occ%0d", o.act, o.andar, o.occ, e.act, e.andar, e.occ); end
    end
  endtask

  task automatic test_bounds();
    int cnt, pulses;
    // Six-floor car asked for floor 7: the edge seen at floor 5 is inconsistent.
    @(negedge clock); b_reset = 1'b0;
    @(negedge clock); b_iniciar = 1'b1;
    @(negedge clock); b_iniciar = 1'b0;
    @(posedge clock); #1;
    checks++; if (b_db !== 4'd2) begin failures++; $display("[TB] FAIL bounds_start got=%0d want=2", b_db); end
    b_temDestino = 1'b1; b_destino = 3'd7;
    cnt = 0; pulses = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clock); #1;
      b_borda = 1'b0;
      if (b_db == 4'd14) break;
      if (b_db == 4'd4) begin
        cnt++;
        if (cnt >= 4) begin b_borda = 1'b1; cnt = 0; pulses++; end
      end
    end
    b_temDestino = 1'b0;
    checks++; if (b_db !== 4'd14) begin failures++; $display("[TB] FAIL bounds_state got=%0d want=14", b_db); end
    checks++; if (pulses != 6) begin failures++; $display("[TB] FAIL bounds_pulses got=%0d want=6", pulses); end
    checks++; if (b_andar !== 3'd5) begin failures++; $display("[TB] FAIL bounds_floor got=%0d want=5", b_andar); end
    checks++; if (b_erro !== 1'b1) begin failures++; $display("[TB] FAIL bounds_erro got=%0b want=1", b_erro); end
    checks++; if ({b_sobe, b_desce} !== 2'b00) begin failures++; $display("[TB] FAIL bounds_motor got=%b want=00", {b_sobe, b_desce}); end

    // Reset asserted mid-travel on the main car clears the motor at once.
    init_dut();
    temDestino = 1'b1; destino = 3'd5; eh_origem = 1'b1;
    for (int c = 0; c < 10; c++) begin @(posedge clock); #1; if (db_estado == 4'd4) break; end
    bordaSensorAtivo = 1'b1;
    @(posedge clock); #1; bordaSensorAtivo = 1'b0;
    for (int c = 0; c < 10; c++) begin @(posedge clock); #1; if (db_estado == 4'd4) break; end
    checks++; if (andar_atual !== 3'd1) begin failures++; $display("[TB] FAIL midtravel_floor got=%0d want=1", andar_atual); end
    checks++; if (motorSubindo !== 1'b1) begin failures++; $display("[TB] FAIL midtravel_motor got=%0b want=1", motorSubindo); end
    #2 reset = 1'b1;
    #1;
    checks++; if (motorSubindo !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_motor got=%0b want=0", motorSubindo); end
    checks++; if (andar_atual !== 3'd0) begin failures++; $display("[TB] FAIL async_reset_floor got=%0d want=0", andar_atual); end
    checks++; if (db_estado !== 4'd0) begin failures++; $display("[TB] FAIL async_reset_state got=%0d want=0", db_estado); end
    init_dut();
  endtask

  task automatic test_random();
    bit done, gapm; int dwell, fm, mc; int s0, prev, dest, gap; bit orig; ev_t e, o;
    for (int i = 0; i < 200; i++) begin
      dest = $urandom_range(0, N - 1);
      orig = 1'($urandom_range(0, 1));
      gap  = $urandom_range(1, 15);
      prev = model_floor;
      s0   = shift_cnt;
      model_push(dest, orig);
      applyStimulus(3'(dest), orig, gap, done, dwell, fm, mc, gapm);
      checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL random_done[%0d] got=%0b want=1", i, done); end
      checks++; if (dwell != TP) begin failures++; $display("[TB] FAIL random_dwell[%0d] got=%0d want=%0d", i, dwell, TP); end
      checks++; if (shift_cnt - s0 != 1) begin failures++; $display("[TB] FAIL random_one_shift[%0d] got=%0d want=1", i, shift_cnt - s0); end
      checks++; if (gapm !== 1'b0) begin failures++; $display("[TB] FAIL random_motor_continuous[%0d] got=%0b want=0", i, gapm); end
      checks++;
      if (dest == prev) begin
        if (mc != 0) begin failures++; $display("[TB] FAIL random_no_motor[%0d] got=%0d want=0", i, mc); end
      end else begin
        if (fm != 1) begin failures++; $display("[TB] FAIL random_motor_latency[%0d] got=%0d want=1", i, fm); end
      end
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("[TB] FAIL random_scoreboard[%0d] got=none want=act%0d", i, e.act); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("[TB] FAIL random_scoreboard[%0d] got=act%0d/floor%0d/occ%0d want=act%0d/floor%0d/occ%0d", i, o.act, o.andar, o.occ, e.act, e.andar, e.occ); end
      end
    end
    checks++; if (both_cnt != 0) begin failures++; $display("[TB] FAIL motors_exclusive got=%0d want=0", both_cnt); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_pickup();
    test_dropoff();
    test_capacity();
    test_watchdog();
    test_bounds();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
